// File: rtl/vref_cal_sar.sv
// Successive-approximation trim controller for the vREF CAL input: binary-searches
// the trim code from a synchronized comparator decision, with a software override path.
package vref_pkg;
    parameter int VrefCalibrationWidth = 5;
endpackage

module vref_cal_sar #(
    parameter int CAL_W         = vref_pkg::VrefCalibrationWidth,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             cmp_i,
    input  logic             override_en_i,
    input  logic [CAL_W-1:0] override_cal_i,
    output logic [CAL_W-1:0] cal_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             cal_valid_o
);

    localparam int               IDX_W    = (CAL_W > 1) ? $clog2(CAL_W) : 1;
    localparam logic [CAL_W-1:0] ONE_CODE = CAL_W'(1);
    localparam logic [CAL_W-1:0] MID_CODE = ONE_CODE << (CAL_W - 1);
    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(CAL_W - 1);
    localparam logic [15:0]      CNT_LOAD = 16'(SETTLE_CYCLES - 1);

    generate
        if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 65535) begin : g_bad_settle
            $error("vref_cal_sar: SETTLE_CYCLES must be within 3..65535");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CAL_W-1:0]   cal_q;
    logic [CAL_W-1:0]   cal_nxt;
    logic [CAL_W-1:0]   cur_bit;
    logic [IDX_W-1:0]   bit_idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic [15:0]        cnt;
    logic [15:0]        cnt_nxt;
    logic               cmp_s1;
    logic               cmp_s2;
    logic               valid_q;
    logic               valid_nxt;
    logic               done_q;
    logic               done_nxt;

    // Two-flop synchronizer for the asynchronous comparator output
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmp_s1 <= 1'b0;
            cmp_s2 <= 1'b0;
        end else begin
            cmp_s1 <= cmp_i;
            cmp_s2 <= cmp_s1;
        end
    end

    // Search state and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cal_q   <= MID_CODE;
            bit_idx <= {IDX_W{1'b0}};
            cnt     <= 16'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cal_q   <= cal_nxt;
            bit_idx <= idx_nxt;
            cnt     <= cnt_nxt;
            valid_q <= valid_nxt;
            done_q  <= done_nxt;
        end
    end

    // Next-state logic: settle countdown, per-bit decision, abort on override
    always_comb begin
        state_nxt = state;
        cal_nxt   = cal_q;
        idx_nxt   = bit_idx;
        cnt_nxt   = cnt;
        valid_nxt = valid_q;
        done_nxt  = 1'b0;
        cur_bit   = ONE_CODE << bit_idx;
        case (state)
            IDLE: begin
                if (start_i && !override_en_i) begin
                    state_nxt = SEARCH;
                    cal_nxt   = MID_CODE;
                    idx_nxt   = TOP_IDX;
                    cnt_nxt   = CNT_LOAD;
                    valid_nxt = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SEARCH: begin
                if (override_en_i) begin
                    state_nxt = IDLE;
                    cal_nxt   = MID_CODE;
                    valid_nxt = 1'b0;
                end else if (cnt != 16'd0) begin
                    cnt_nxt = cnt - 16'd1;
                end else begin
                    // Output above target: the trial bit overshoots, drop it
                    if (cmp_s2) begin
                        cal_nxt = cal_q & ~cur_bit;
                    end else begin
                        cal_nxt = cal_q;
                    end
                    if (bit_idx != {IDX_W{1'b0}}) begin
                        cal_nxt = cal_nxt | (cur_bit >> 1);
                        idx_nxt = bit_idx - IDX_W'(1);
                        cnt_nxt = CNT_LOAD;
                    end else begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b1;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign cal_o       = override_en_i ? override_cal_i : cal_q;
    assign busy_o      = (state == SEARCH);
    assign done_o      = done_q;
    assign cal_valid_o = valid_q;

endmodule

// File: tb/tb_vref_cal_sar.sv
// Bench for vref_cal_sar: a timeline model of the search checked every cycle,
// plus directed scenarios with hand-computed codes for a 760 mV target and the extremes.
module tb_vref_cal_sar;

    localparam int S     = 16;
    localparam int CAL_W = 5;

    logic       clk = 1'b0;
    logic       rst, start, cmp, ovr;
    logic [4:0] ovr_cal;
    logic [4:0] cal;
    logic       busy, done, valid;
    int         cmp_mode;

    logic       rst3, start3, cmp3;
    logic [4:0] cal3;
    logic       busy3, done3, valid3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // vREF behaviour: VOUT = 672 + 8*code mV, comparator trips above 760 mV
    function automatic logic cmp_of(input int mode, input int code);
        case (mode)
            1:       return 1'b1;
            2:       return 1'b0;
            default: return (672 + 8 * code) > 760;
        endcase
    endfunction

    always_comb cmp  = cmp_of(cmp_mode, int'(cal));
    always_comb cmp3 = cmp_of(0, int'(cal3));

    vref_cal_sar #(.CAL_W(CAL_W), .SETTLE_CYCLES(S)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .cmp_i(cmp),
        .override_en_i(ovr), .override_cal_i(ovr_cal),
        .cal_o(cal), .busy_o(busy), .done_o(done), .cal_valid_o(valid)
    );

    vref_cal_sar #(.CAL_W(CAL_W), .SETTLE_CYCLES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst3), .start_i(start3), .cmp_i(cmp3),
        .override_en_i(1'b0), .override_cal_i(5'd0),
        .cal_o(cal3), .busy_o(busy3), .done_o(done3), .cal_valid_o(valid3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: after a start the outputs follow a fixed schedule of trial codes
    bit         m_on = 1'b0;
    bit         m_busy, m_done, m_valid;
    int         m_n;
    logic [4:0] m_cal, m_final;
    logic [4:0] m_trials [5];

    always @(posedge clk) begin
        if (rst) begin
            m_on = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_valid = 1'b0;
            m_cal = 5'd16; m_n = 0;
        end else if (m_on) begin
            m_done = 1'b0;
            if (m_busy && ovr) begin
                m_busy = 1'b0; m_valid = 1'b0; m_cal = 5'd16;
            end else if (m_busy) begin
                m_n++;
                if (m_n == CAL_W * S) begin
                    m_busy = 1'b0; m_valid = 1'b1; m_done = 1'b1; m_cal = m_final;
                end else begin
                    m_cal = m_trials[m_n / S];
                end
            end else if (start && !ovr) begin
                // Result: largest code whose output is not above the target
                m_final = 5'd0;
                for (int c = 0; c < 32; c++) begin
                    if (!cmp_of(cmp_mode, c)) m_final = 5'(c);
                end
                for (int j = 0; j < 5; j++) begin
                    m_trials[j] = 5'((((int'(m_final)) >> (5 - j)) << (5 - j)) | (1 << (4 - j)));
                end
                m_busy = 1'b1; m_n = 0; m_valid = 1'b0; m_cal = m_trials[0];
            end
        end
        #1;
        if (m_on) begin
            check("model_cal_o", cal, ovr ? ovr_cal : m_cal);
            check("model_busy_o", busy, m_busy);
            check("model_done_o", done, m_done);
            check("model_cal_valid_o", valid, m_valid);
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Runs one search from a start pulse and checks trial codes and completion timing
    task automatic calib(input string tag, input int mode,
                         input logic [4:0] t0, input logic [4:0] t1, input logic [4:0] t2,
                         input logic [4:0] t3, input logic [4:0] t4, input logic [4:0] fin);
        logic [4:0] tr [5];
        tr[0] = t0; tr[1] = t1; tr[2] = t2; tr[3] = t3; tr[4] = t4;
        cmp_mode = mode;
        pulse_start();
        for (int e = 1; e <= 81; e++) begin
            @(posedge clk); #2;
            if (e % S == 8) check({tag, "_trial"}, cal, tr[e / S]);
            if (e == 79) check({tag, "_done_early"}, done, 1'b0);
            if (e == 80) begin
                check({tag, "_done"}, done, 1'b1);
                check({tag, "_final"}, cal, fin);
                check({tag, "_valid"}, valid, 1'b1);
                check({tag, "_busy_end"}, busy, 1'b0);
            end
            if (e == 81) check({tag, "_done_once"}, done, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rst3 = 1'b1; start = 1'b0; start3 = 1'b0;
        ovr = 1'b0; ovr_cal = 5'd0; cmp_mode = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0; rst3 = 1'b0;
        @(posedge clk); #2;
        check("reset_cal_o", cal, 5'd16);
        check("reset_busy_o", busy, 1'b0);
        check("reset_done_o", done, 1'b0);
        check("reset_valid_o", valid, 1'b0);

        calib("cal760", 0, 5'd16, 5'd8, 5'd12, 5'd10, 5'd11, 5'd11);
        calib("tie1", 1, 5'd16, 5'd8, 5'd4, 5'd2, 5'd1, 5'd0);
        calib("tie0", 2, 5'd16, 5'd24, 5'd28, 5'd30, 5'd31, 5'd31);

        // Abort at cycle 40 of a search
        cmp_mode = 0;
        pulse_start();
        repeat (40) @(posedge clk);
        @(negedge clk); ovr_cal = 5'd7; ovr = 1'b1;
        #1;
        check("abort_cal_same_cycle", cal, 5'd7);
        check("abort_busy_before_edge", busy, 1'b1);
        @(posedge clk); #2;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", valid, 1'b0);
        repeat (3) begin
            @(posedge clk); #2;
            check("abort_no_done", done, 1'b0);
        end
        @(negedge clk); ovr = 1'b0;
        #1;
        check("abort_release_cal", cal, 5'd16);

        // start held high through a whole search, then restarts right after done
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 81; e++) begin
            @(posedge clk); #2;
            if (e < 80) check("held_busy", busy, 1'b1);
            if (e == 80) begin
                check("held_done", done, 1'b1);
                check("held_valid", valid, 1'b1);
            end
            if (e == 81) begin
                check("held_restart_busy", busy, 1'b1);
                check("held_restart_valid", valid, 1'b0);
                check("held_restart_cal", cal, 5'd16);
            end
        end
        @(negedge clk); start = 1'b0;
        repeat (80) @(posedge clk);
        #2;
        check("held_second_done", done, 1'b1);

        // start while overridden is ignored and the result is kept
        @(negedge clk); ovr = 1'b1; ovr_cal = 5'd21; start = 1'b1;
        repeat (5) begin
            @(posedge clk); #2;
            check("ovr_start_busy", busy, 1'b0);
            check("ovr_start_valid", valid, 1'b1);
            check("ovr_start_cal", cal, 5'd21);
        end
        @(negedge clk); ovr = 1'b0; start = 1'b0;
        #1;
        check("ovr_release_cal", cal, 5'd11);

        // Reset at cycle 30 of a search
        pulse_start();
        repeat (29) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #2;
        check("midrst_cal", cal, 5'd16);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_valid", valid, 1'b0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);

        // SETTLE_CYCLES=3 instance, target 760 mV
        @(negedge clk); start3 = 1'b1;
        @(posedge clk); #2;
        check("s3_trial0", cal3, 5'd16);
        @(negedge clk); start3 = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            logic [4:0] tr3 [5];
            tr3[0] = 5'd16; tr3[1] = 5'd8; tr3[2] = 5'd12; tr3[3] = 5'd10; tr3[4] = 5'd11;
            @(posedge clk); #2;
            if (e % 3 == 1 && e < 15) check("s3_trial", cal3, tr3[e / 3]);
            if (e < 15) check("s3_busy", busy3, 1'b1);
            if (e < 15) check("s3_no_done", done3, 1'b0);
            if (e == 15) begin
                check("s3_done", done3, 1'b1);
                check("s3_final", cal3, 5'd11);
                check("s3_valid", valid3, 1'b1);
            end
            if (e == 16) begin
                check("s3_done_once", done3, 1'b0);
                check("s3_idle", busy3, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vref_cal_sar.md
# vref_cal_sar

Successive-approximation calibration controller that drives the 5-bit `CAL` trim of the vREF voltage reference. It sits directly upstream of vREF. It binary-searches the trim code using a single comparator decision (vREF output vs. target) and holds the resulting code on the vREF calibration input. A software override path bypasses the search.

## Interface
- `CAL_W`, default `vref_pkg::VrefCalibrationWidth` (5): trim code width.
- `SETTLE_CYCLES`, default 16: cycles each trial code is held before its decision. Legal range 3..2^16-1; the elaboration check must fail outside it.
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  level, sampled each edge. Starts a calibration when the block is idle and not overridden.
- `cmp_i`  in  1  asynchronous comparator output. 1 means vREF output is above the target. Passes through a 2-flop synchronizer inside the block.
- `override_en_i`  in  1  selects the override code and aborts or inhibits calibration.
- `override_cal_i`  in  CAL_W  code driven out while `override_en_i`=1.
- `cal_o`  out  CAL_W  trim code; connects to vREF `CAL`.
- `busy_o`  out  1  calibration in progress.
- `done_o`  out  1  one-cycle pulse when a calibration completes.
- `cal_valid_o`  out  1  `cal_q` holds a completed calibration result.

## Operation
- State machine has two states, IDLE and SEARCH. Registers:
  - `cal_q[CAL_W]`
  - `bit_idx`
  - `cnt` (settle down-counter)
  - `cmp_s1`, `cmp_s2` (synchronizer)
  - `valid_q`
  - `done_q`
- `cal_o` = `override_en_i` ? `override_cal_i` : `cal_q`. This mux is combinational.
- **IDLE → SEARCH** when `start_i`=1 and `override_en_i`=0. On that edge:
  - `cal_q` ← only bit CAL_W-1 set (mid-code, nominal output)
  - `bit_idx` ← CAL_W-1
  - `cnt` ← SETTLE_CYCLES-1
  - `valid_q` ← 0
- **SEARCH**, edge with `cnt`≠0: `cnt` decrements.
- **SEARCH**, edge with `cnt`=0: this is the decision for `bit_idx`, taken from `cmp_s2`.
  - If `cmp_s2`=1, clear `cal_q[bit_idx]`; otherwise keep it.
  - If `bit_idx`>0: set `cal_q[bit_idx-1]`, decrement `bit_idx`, reload `cnt` to SETTLE_CYCLES-1.
  - If `bit_idx`=0: go to IDLE, `valid_q` ← 1, `done_q` ← 1.
- Result: the largest code whose output is not above the target.
  - `cmp` always 1 → result 0.
  - `cmp` always 0 → result 2^CAL_W-1.
- `start_i` is ignored while in SEARCH; there is no restart mid-search.
- `start_i` held high in IDLE after completion starts a new calibration on the next edge. This also clears `valid_q`.
- **Abort:** `override_en_i`=1 while in SEARCH. On the next edge:
  - go to IDLE
  - `cal_q` ← mid-code
  - `valid_q` ← 0
  - no `done_o` pulse
- `override_en_i`=1 in IDLE: `start_i` is ignored, and `cal_q`/`valid_q` are unchanged.
- `busy_o` = (state==SEARCH). `done_o` = `done_q`, which is cleared on every edge where it is not being set.

## Timing
- Reset values:
  - state IDLE
  - `cal_q` = mid-code (16 for CAL_W=5)
  - `cal_o` = mid-code (or `override_cal_i` if override is high)
  - `busy_o` = 0, `done_o` = 0, `cal_valid_o` = 0
  - `cmp_s1` = `cmp_s2` = 0
  - `cnt` = 0, `bit_idx` = 0
- Reset mid-search returns to reset values on that edge, with no `done_o`.
- Timing of a calibration, with `start_i` sampled at edge 0:
  - `busy_o` is high from edge 0 up to edge CAL_W·SETTLE_CYCLES.
  - The decision for bit k (MSB first, j = CAL_W-1-k) occurs at edge (j+1)·SETTLE_CYCLES.
  - `done_o` is high for the single cycle after edge CAL_W·SETTLE_CYCLES.
  - `cal_valid_o` rises with `done_o`.
  - The final `cal_o` is stable from the same edge.
- Defaults: 80 cycles from start to done.
- The `cmp_i` path has 2 cycles of synchronizer latency. The decision therefore reflects `cmp_i` as of 2 cycles before the decision edge, i.e. after SETTLE_CYCLES-2 cycles of settling on the trial code.
- Each trial code is held for exactly SETTLE_CYCLES cycles.
- Override effect on `cal_o` is same-cycle. The abort itself takes effect at the next edge.

## Test plan
- **Reset:** assert `rst_i` 2 cycles.
  - Expected: `cal_o`=16, `busy_o`=0, `done_o`=0, `cal_valid_o`=0.
- **Calibrate to 760 mV:** behavioural vREF model (VOUT=672+8·cal), `cmp_i`=(VOUT>760), pulse `start_i`.
  - Expected trial sequence: 16, 8, 12, 10, 11.
  - Expected end state: `done_o` pulses at cycle 81, `cal_o`=11, `cal_valid_o`=1.
- **Extremes:**
  - `cmp_i` tied 1 → `cal_o`=0.
  - `cmp_i` tied 0 → `cal_o`=31.
  - Both cases: `done_o` after 80 cycles.
- **Abort:**
  - Raise `override_en_i` with `override_cal_i`=7 at cycle 40 of a search. Expected: `cal_o`=7 the same cycle, `busy_o`=0 next cycle, no `done_o`, `cal_valid_o`=0.
  - Drop the override. Expected: `cal_o`=16.
- **Ignored starts:**
  - `start_i` held high for an entire search. Expected: a single 80-cycle search, then a new search begins on the edge after done and `cal_valid_o` clears.
  - `start_i` with override active. Expected: no search.
- **Mid-search reset and SETTLE_CYCLES=3:**
  - `rst_i` at cycle 30. Expected: outputs return to reset values on the next edge.
  - Rerun with SETTLE_CYCLES=3. Expected: done at cycle 16 and a correct code for target 760 (result 11).
